// File: rtl/lsr_stream.sv
// rtl/lsr_stream.sv - streaming least-squares line fit with a shared sequential divider
//
// Accumulates N, Sx, Sy, Sxx, Sxy over a valid/ready sample stream, then fits
// y = m*x + b in signed fixed point Q(OW-FRAC).FRAC.
//
// Ports:
//   clk      clock, all logic on rising edge
//   rst      synchronous active-low reset
//   start    begin a batch (honoured only when idle)
//   mode     0: use s_x, 1: x is the sample index
//   s_valid / s_ready / s_x / s_y / s_last   sample stream
//   busy     high from start acceptance until the cycle after done
//   done     one-cycle pulse, m/b/err valid
//   m, b     saturated slope and intercept
//   count    samples accepted in the current/last batch
//   err      degenerate fit (denominator zero)
module lsr_stream #(
  parameter int DW    = 16,
  parameter int MAX_N = 64,
  parameter int FRAC  = 8,
  parameter int OW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DW-1:0]   s_x,
  input  logic signed [DW-1:0]   s_y,
  input  logic                   s_last,
  output logic                   busy,
  output logic                   done,
  output logic signed [OW-1:0]   m,
  output logic signed [OW-1:0]   b,
  output logic [$clog2(MAX_N):0] count,
  output logic                   err
);
  localparam int CW  = $clog2(MAX_N) + 1;
  localparam int AW  = 2*DW + $clog2(MAX_N) + 2;   // accumulator width
  localparam int PW  = 2*AW + 2;                   // numerator / denominator width
  localparam int XW  = PW + FRAC + OW;             // divider working width
  localparam int ITW = $clog2(OW);
  localparam logic [ITW-1:0] ITER_LAST = ITW'(OW - 1);
  localparam logic [CW-1:0]  N_LAST    = CW'(MAX_N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_CALC_M, S_DIV_M, S_CALC_B, S_DIV_B, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]        n;
  logic signed [AW-1:0] acc_sx, acc_sy, acc_sxx, acc_sxy;
  logic                 mode_r, err_r;
  logic [XW-1:0]        rem, dsh;
  logic [OW-1:0]        quo;
  logic [ITW-1:0]       iter;
  logic                 div_neg, div_ovf;
  logic signed [OW:0]   m_full_r;

  function automatic logic [PW-1:0] abs_p(input logic signed [PW-1:0] v);
    return v[PW-1] ? PW'(-v) : PW'(v);
  endfunction

  function automatic logic signed [OW:0] signed_q(input logic [OW-1:0] q, input logic neg);
    logic signed [OW:0] mag;
    mag = {1'b0, q};
    return neg ? -mag : mag;
  endfunction

  function automatic logic signed [OW-1:0] sat(input logic signed [OW:0] v);
    if (v[OW] != v[OW-1])
      return v[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    return v[OW-1:0];
  endfunction

  logic take, close;
  assign take  = s_ready && s_valid;
  assign close = take && (s_last || n == N_LAST);

  logic signed [AW-1:0] x_ext, y_ext;
  assign x_ext = mode_r ? $signed(AW'(n)) : AW'(s_x);
  assign y_ext = AW'(s_y);

  logic signed [PW-1:0] n_w, sx_w, sy_w, sxx_w, sxy_w, num_w, den_w, bnum_w;
  assign n_w   = $signed(PW'(n));
  assign sx_w  = PW'(acc_sx);
  assign sy_w  = PW'(acc_sy);
  assign sxx_w = PW'(acc_sxx);
  assign sxy_w = PW'(acc_sxy);
  assign num_w = n_w * sxy_w - sx_w * sy_w;
  assign den_w = n_w * sxx_w - sx_w * sx_w;

  // Divider result in signed form; an overflowing quotient is pinned to the
  // largest magnitude so that the final saturation clips it.
  logic signed [OW:0] q_signed, m_full_c;
  assign q_signed = signed_q(div_ovf ? {OW{1'b1}} : quo, div_neg);
  assign m_full_c = err_r ? '0 : q_signed;
  assign bnum_w   = (sy_w <<< FRAC) - PW'(m_full_c) * sx_w;

  // Operand selection for the one shared divider: slope first, then intercept.
  logic [XW-1:0] ld_rem, ld_div;
  logic          ld_neg;
  always_comb begin
    ld_rem = XW'(abs_p(bnum_w));
    ld_div = XW'(n);
    ld_neg = bnum_w[PW-1];
    if (state == S_CALC_M) begin
      ld_rem = XW'(abs_p(num_w)) << FRAC;
      ld_div = XW'(abs_p(den_w));
      ld_neg = num_w[PW-1] ^ den_w[PW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    case (state)
      S_IDLE:   if (start && !busy) state_nx = S_ACC;
      S_ACC: begin
        s_ready = 1'b1;
        if (close) state_nx = S_CALC_M;
      end
      S_CALC_M: state_nx = S_DIV_M;
      S_DIV_M:  if (err_r || iter == ITER_LAST) state_nx = S_CALC_B;
      S_CALC_B: state_nx = S_DIV_B;
      S_DIV_B:  if (iter == ITER_LAST) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n        <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_sxx  <= '0;
      acc_sxy  <= '0;
      mode_r   <= 1'b0;
      err_r    <= 1'b0;
      rem      <= '0;
      dsh      <= '0;
      quo      <= '0;
      iter     <= '0;
      div_neg  <= 1'b0;
      div_ovf  <= 1'b0;
      m_full_r <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      m        <= '0;
      b        <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            n       <= '0;
            acc_sx  <= '0;
            acc_sy  <= '0;
            acc_sxx <= '0;
            acc_sxy <= '0;
            mode_r  <= mode;
            busy    <= 1'b1;
          end
        end
        S_ACC: begin
          if (take) begin
            acc_sx  <= acc_sx + x_ext;
            acc_sy  <= acc_sy + y_ext;
            acc_sxx <= acc_sxx + x_ext * x_ext;
            acc_sxy <= acc_sxy + x_ext * y_ext;
            n       <= n + 1'b1;
          end
        end
        S_CALC_M, S_CALC_B: begin
          if (state == S_CALC_M) err_r    <= (den_w == '0);
          else                   m_full_r <= m_full_c;
          rem     <= ld_rem;
          dsh     <= ld_div << (OW - 1);
          div_neg <= ld_neg;
          div_ovf <= ld_rem >= (ld_div << OW);
          quo     <= '0;
          iter    <= '0;
        end
        S_DIV_M, S_DIV_B: begin
          // Restoring division against a right-shifting divisor, MSB first.
          if (!(state == S_DIV_M && err_r)) begin
            if (rem >= dsh) begin
              rem <= rem - dsh;
              quo <= {quo[OW-2:0], 1'b1};
            end else begin
              quo <= {quo[OW-2:0], 1'b0};
            end
            dsh  <= dsh >> 1;
            iter <= iter + 1'b1;
          end
        end
        S_DONE: begin
          m    <= sat(m_full_r);
          b    <= sat(q_signed);
          err  <= err_r;
          done <= 1'b1;
        end
        default: ;
      endcase
      // Hold busy through the done cycle so a new start lands one cycle later.
      if (done) busy <= 1'b0;
    end
  end

  assign count = n;

endmodule

// File: tb/tb_lsr_stream.sv
// tb/tb_lsr_stream.sv - self-checking bench for lsr_stream
module tb_lsr_stream;
  localparam int DW      = 16;
  localparam int MAX_N   = 64;
  localparam int FRAC    = 8;
  localparam int OW      = 32;
  localparam int CW      = $clog2(MAX_N) + 1;
  localparam int LAT     = 2*OW + 3;
  localparam int LAT_DEG = OW + 4;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic signed [DW-1:0] s_x = '0, s_y = '0;
  logic s_ready, busy, done, err;
  logic signed [OW-1:0] m, b;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  string tag = "init";
  int xs[MAX_N];
  int ys[MAX_N];

  always #5 clk = ~clk;

  lsr_stream #(.DW(DW), .MAX_N(MAX_N), .FRAC(FRAC), .OW(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_last(s_last),
    .busy(busy), .done(done), .m(m), .b(b), .count(count), .err(err)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog [%s]: got timeout, expected finish", tag);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi = (longint'(1) <<< (OW - 1)) - 1;
    longint lo = -(longint'(1) <<< (OW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Straight least-squares formulas on exact integers.
  task automatic model(input bit md, input int n, output longint m_e, output longint b_e,
                       output bit err_e);
    longint sx = 0, sy = 0, sxx = 0, sxy = 0, x, num, den, mf, bf;
    longint scale = longint'(1) <<< FRAC;
    for (int i = 0; i < n; i++) begin
      x = md ? longint'(i) : longint'(xs[i]);
      sx += x;
      sy += ys[i];
      sxx += x * x;
      sxy += x * ys[i];
    end
    num = n * sxy - sx * sy;
    den = n * sxx - sx * sx;
    err_e = (den == 0);
    mf = err_e ? 0 : (num * scale) / den;
    bf = (sy * scale - mf * sx) / n;
    m_e = sat(mf);
    b_e = sat(bf);
  endtask

  task automatic feed(input bit md, input int n, input bit use_last, input int gap_pct);
    int i = 0;
    int cyc = 0;
    bit acc;
    mode = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    while (i < n && cyc < 4*MAX_N + 100) begin
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_x = DW'(xs[i]);
      s_y = DW'(ys[i]);
      s_last = use_last && (i == n - 1);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (i < n) check("feed_timeout", i, n);
    check("ready_after_close", s_ready, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input bit md, input int n, input bit use_last, input int gap_pct,
                               input longint m_e, input longint b_e, input bit err_e);
    int lat;
    feed(md, n, use_last, gap_pct);
    wait_done(lat);
    check("done_seen", done, 1);
    check("latency", lat, err_e ? LAT_DEG : LAT);
    check("m", m, m_e);
    check("b", b, b_e);
    check("err", err, err_e);
    check("count", count, n);
    check("busy_at_done", busy, 1);
    // A start while busy is still high must be ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_fall", busy, 0);
    check("start_ignored", s_ready, 0);
  endtask

  typedef struct {
    bit     md;
    int     n;
    int     x[8];
    int     y[8];
    longint m_e;
    longint b_e;
    bit     err_e;
  } vec_t;

  vec_t vecs[4];

  initial begin
    longint m_e, b_e;
    bit err_e, md;
    int n, seen;

    vecs[0].md = 1'b1; vecs[0].n = 7;
    vecs[0].x = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].y = '{5, 8, 11, 14, 17, 20, 23, 0};
    vecs[0].m_e = 768;  vecs[0].b_e = 1280; vecs[0].err_e = 1'b0;
    vecs[1].md = 1'b0; vecs[1].n = 4;
    vecs[1].x = '{-2, 0, 2, 4, 0, 0, 0, 0};
    vecs[1].y = '{7, 3, -1, -5, 0, 0, 0, 0};
    vecs[1].m_e = -512; vecs[1].b_e = 768;  vecs[1].err_e = 1'b0;
    vecs[2].md = 1'b0; vecs[2].n = 3;
    vecs[2].x = '{0, 1, 2, 0, 0, 0, 0, 0};
    vecs[2].y = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[2].m_e = 128;  vecs[2].b_e = 42;   vecs[2].err_e = 1'b0;
    vecs[3].md = 1'b0; vecs[3].n = 5;
    vecs[3].x = '{4, 4, 4, 4, 4, 0, 0, 0};
    vecs[3].y = '{1, 2, 3, 4, 5, 0, 0, 0};
    vecs[3].m_e = 0;    vecs[3].b_e = 768;  vecs[3].err_e = 1'b1;

    tag = "reset";
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_m", m, 0);
    check("rst_b", b, 0);
    check("rst_count", count, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      tag = $sformatf("vec%0d", v);
      for (int i = 0; i < 8; i++) begin
        xs[i] = vecs[v].x[i];
        ys[i] = vecs[v].y[i];
      end
      run_and_check(vecs[v].md, vecs[v].n, 1'b1, (v % 2) * 30,
                    vecs[v].m_e, vecs[v].b_e, vecs[v].err_e);
    end

    tag = "max_n";
    for (int i = 0; i < MAX_N; i++) begin
      xs[i] = 0;
      ys[i] = 2;
    end
    run_and_check(1'b1, MAX_N, 1'b0, 40, 0, 512, 1'b0);

    for (int r = 0; r < 8; r++) begin
      tag = $sformatf("rand%0d", r);
      md = 1'($urandom_range(0, 1));
      n = (r == 0) ? 1 : int'($urandom_range(2, MAX_N));
      for (int i = 0; i < n; i++) begin
        xs[i] = int'($urandom_range(0, 2000)) - 1000;
        ys[i] = int'($urandom_range(0, 100)) - 50;
      end
      model(md, n, m_e, b_e, err_e);
      run_and_check(md, n, (n < MAX_N) ? 1'b1 : 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 50)), m_e, b_e, err_e);
    end

    tag = "reset_mid_div";
    for (int i = 0; i < 8; i++) begin
      xs[i] = vecs[0].x[i];
      ys[i] = vecs[0].y[i];
    end
    feed(1'b1, 7, 1'b1, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_s_ready", s_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    check("mid_m", m, 0);
    check("mid_b", b, 0);
    check("mid_count", count, 0);
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_reset", seen, 0);

    tag = "start_with_reset";
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b0;
    check("sr_busy", busy, 0);
    check("sr_s_ready", s_ready, 0);
    @(posedge clk); #1;

    tag = "after_reset";
    for (int i = 0; i < 8; i++) begin
      xs[i] = vecs[1].x[i];
      ys[i] = vecs[1].y[i];
    end
    run_and_check(1'b0, 4, 1'b1, 20, -512, 768, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsr_stream.md
# lsr_stream

Streaming, parametrised least-squares linear-regression engine; successor to the fixed 7-point LSR block. Accepts up to MAX_N samples over a valid/ready stream, either (x, y) pairs or y-only with x taken as the sample index. After the last sample it computes slope m and intercept b as signed fixed-point values using a shared sequential divider. Sits between the sample source (CSV-fed bench, later the acquisition front end) and downstream consumers of the fitted line.

## Interface
- DW, 16, sample width (signed two's complement, s_x and s_y)
- MAX_N, 64, maximum samples per batch (≥ 2)
- FRAC, 8, fractional bits of m and b
- OW, 32, width of m and b (signed, Q(OW-FRAC).FRAC)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst = 0 resets)
- start  in  1  pulse in IDLE: clear accumulators, latch mode, begin batch
- mode  in  1  0 = pair mode (s_x used), 1 = index mode (x = 0,1,2,…)
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_x  in  DW  signed x (ignored in index mode)
- s_y  in  DW  signed y
- s_last  in  1  marks final sample of batch
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, results valid
- m  out  OW  slope, signed fixed point, saturated
- b  out  OW  intercept, signed fixed point, saturated
- count  out  clog2(MAX_N)+1  samples accepted in current/last batch
- err  out  1  degenerate fit (denominator zero), valid with done

## Operation
- States: IDLE → ACC → CALC_M → DIV_M → CALC_B → DIV_B → DONE → IDLE.
- IDLE: s_ready = 0. start = 1 → clear N, Sx, Sy, Sxx, Sxy; latch mode; go ACC. start outside IDLE ignored.
- ACC: s_ready = 1. Per accepted sample: x = (mode ? N : s_x); Sx += x, Sy += y, Sxx += x², Sxy += x·y, N += 1. Accumulators sized 2·DW + clog2(MAX_N) + 2 bits; no overflow for any legal input.
- Batch closes on accepted sample with s_last = 1, or on the MAX_N-th accepted sample (s_last ignored beyond that; s_ready drops).
- CALC_M: num = N·Sxy − Sx·Sy; D = N·Sxx − Sx². D == 0 (includes N = 1 and all-equal x) → err = 1, m forced 0, skip DIV_M.
- DIV_M: m_full = (num << FRAC) / D, signed, truncated toward zero; restoring divider, one quotient bit per cycle, OW iterations.
- CALC_B: bnum = (Sy << FRAC) − m_full·Sx (m_full = 0 when err).
- DIV_B: b_full = bnum / N, truncated toward zero, same divider, OW iterations.
- DONE: m, b = m_full, b_full saturated to signed OW range; done = 1 for one cycle; return IDLE. m, b, err, count held until next done or reset.
- Internal products and quotients are wide enough that only the final saturation can clip.

## Timing
- Reset: state IDLE; s_ready, busy, done, err = 0; m, b, count = 0; accumulators cleared. Reset mid-batch or mid-divide abandons work; no done is issued.
- start sampled in IDLE → ACC next cycle; busy rises same edge.
- Throughput in ACC: one sample per cycle; s_valid gaps allowed; N increments only on handshake.
- From the edge accepting the closing sample: CALC_M 1 cycle, DIV_M OW cycles (skipped when err, replaced by 1 cycle), CALC_B 1, DIV_B OW, DONE 1. Non-degenerate: done high exactly 2·OW + 3 cycles after the closing handshake (67 for OW = 32).
- busy falls in the cycle after done; start accepted again the cycle after that.
- start and reset in the same cycle: reset wins.

## Test plan
- Index mode, N = 7, y = 5,8,11,14,17,20,23 with s_last on 7th → m = 768 (3.0), b = 1280 (5.0), err = 0, count = 7, done 67 cycles after last handshake.
- Pair mode, x = {−2,0,2,4}, y = {7,3,−1,−5} → m = −512, b = 768.
- Truncation: pair mode x = {0,1,2}, y = {0,1,1} → m = 128 (0.5), b = 42 (42.67 truncated).
- Degenerate: pair mode, x = 4 for all 5 samples, y = {1,2,3,4,5} → err = 1, m = 0, b = 768 (mean 3.0).
- MAX_N auto-close with random s_valid gaps: MAX_N index-mode samples of y = 2, no s_last → s_ready drops after sample MAX_N, count = MAX_N, m = 0, b = 512.
- Reset (rst = 0 one cycle) midway through DIV_M → all outputs 0, no done pulse; a new start then runs a clean batch with correct results.
